// File: rtl/pattern_sequencer_pkg.sv
// pattern_sequencer_pkg
//   Shared types and constants for the VGA pattern sequencer.
//   Contents: PATTERN_OFF code, FSM state encoding, pending-request encoding,
//   frame counter width and the wrapping step helper.
package pattern_sequencer_pkg;

   localparam logic [3:0] PATTERN_OFF = 4'h0;
   localparam int         FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_BLANK = 2'd3
   } seq_state_t;

   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,
      PEND_NEXT = 2'd1,
      PEND_PREV = 2'd2
   } pend_t;

   // One step up or down inside [first, last], wrapping at both ends.
   function automatic logic [3:0] step_pattern(input logic [3:0] cur,
                                               input logic       up,
                                               input logic [3:0] first,
                                               input logic [3:0] last);
      logic [3:0] res;
      if (up) res = (cur >= last)  ? first : cur + 4'd1;
      else    res = (cur <= first) ? last  : cur - 4'd1;
      return res;
   endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if
//   Bundles the sequencer's sync/request inputs and pattern outputs.
//   slave  : the sequencer (consumes VSync/requests, drives pattern outputs)
//   master : the surrounding logic (drives VSync/requests, observes outputs)
//   Signals: i_VSync, i_Next, i_Prev, i_Auto_En, o_Pattern[3:0],
//            o_Pattern_Change, o_Frame_Count[15:0]
interface pattern_sequencer_if;
   import pattern_sequencer_pkg::*;

   logic                   i_VSync;
   logic                   i_Next;
   logic                   i_Prev;
   logic                   i_Auto_En;
   logic [3:0]             o_Pattern;
   logic                   o_Pattern_Change;
   logic [FRAME_CNT_W-1:0] o_Frame_Count;

   modport slave (
      input  i_VSync, i_Next, i_Prev, i_Auto_En,
      output o_Pattern, o_Pattern_Change, o_Frame_Count
   );

   modport master (
      output i_VSync, i_Next, i_Prev, i_Auto_En,
      input  o_Pattern, o_Pattern_Change, o_Frame_Count
   );

endinterface

// File: rtl/pattern_sequencer_vsync_edge_detect.sv
// pattern_sequencer_vsync_edge_detect
//   Registers VSync and flags its falling edge (end of the visible frame).
//   Ports: i_Clk, i_Rst (async, active-high), i_VSync,
//          o_Frame_Boundary (high for the one cycle where r_VSync=1, i_VSync=0)
module pattern_sequencer_vsync_edge_detect (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_VSync,
   output logic o_Frame_Boundary
);

   logic r_VSync;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) r_VSync <= 1'b0;
      else       r_VSync <= i_VSync;
   end

   assign o_Frame_Boundary = r_VSync & ~i_VSync;

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//   Selects the VGA test pattern. Cycles FIRST_PATTERN..NUM_PATTERNS-1 every
//   FRAMES_PER_PATTERN frames (auto) or on Next/Prev pulses (manual); every
//   change lands on a frame boundary (VSync falling edge) so frames never tear.
//   Ports: i_Clk, i_Rst (async, active-high), bus (pattern_sequencer_if.slave)
//   Optional: define PATTERN_SEQ_BLANK_EN to insert one black frame per step.
module pattern_sequencer
   import pattern_sequencer_pkg::*;
#(
   parameter int NUM_PATTERNS       = 7,
   parameter int FIRST_PATTERN      = 1,
   parameter int FRAMES_PER_PATTERN = 60
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   pattern_sequencer_if.slave  bus
);

   localparam logic [3:0]             FIRST_PAT = 4'(FIRST_PATTERN);
   localparam logic [3:0]             LAST_PAT  = 4'(NUM_PATTERNS - 1);
   localparam logic [FRAME_CNT_W-1:0] CNT_LAST  = FRAME_CNT_W'(FRAMES_PER_PATTERN - 1);
   localparam logic [FRAME_CNT_W-1:0] CNT_MAX   = '1;

   logic                   fb;
   seq_state_t             state, state_n;
   pend_t                  pending, pending_n;
   logic [3:0]             pattern, pattern_n;
   logic                   change, change_n;
   logic [FRAME_CNT_W-1:0] cnt, cnt_n;
   logic                   consume;
   logic [3:0]             step_to;
   logic                   do_step;
   seq_state_t             mode_st;

   pattern_sequencer_vsync_edge_detect u_edge (
      .i_Clk            (i_Clk),
      .i_Rst            (i_Rst),
      .i_VSync          (bus.i_VSync),
      .o_Frame_Boundary (fb)
   );

   assign mode_st = bus.i_Auto_En ? ST_RUN : ST_HOLD;

`ifdef PATTERN_SEQ_BLANK_EN
   logic [3:0] target, target_n;
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) target <= PATTERN_OFF;
      else       target <= target_n;
   end
`endif

   // Main FSM: decides the pattern, counter and state for the edge ending an FB.
   always_comb begin
      state_n   = state;
      pattern_n = pattern;
      cnt_n     = cnt;
      change_n  = 1'b0;
      consume   = 1'b0;
      do_step   = 1'b0;
      step_to   = pattern;
`ifdef PATTERN_SEQ_BLANK_EN
      target_n  = target;
`endif
      if (fb) begin
         case (state)
            ST_IDLE: begin
               // First frame after reset: come up on FIRST_PATTERN, drop any request.
               pattern_n = FIRST_PAT;
               change_n  = 1'b1;
               cnt_n     = '0;
               consume   = 1'b1;
               state_n   = mode_st;
            end
            ST_RUN, ST_HOLD: begin
               // A manual request outranks the auto advance.
               if (pending != PEND_NONE) begin
                  consume = 1'b1;
                  do_step = 1'b1;
                  step_to = step_pattern(pattern, pending == PEND_NEXT, FIRST_PAT, LAST_PAT);
               end else if (state == ST_RUN && cnt == CNT_LAST) begin
                  do_step = 1'b1;
                  step_to = step_pattern(pattern, 1'b1, FIRST_PAT, LAST_PAT);
               end else begin
                  cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                  state_n = mode_st;
               end
            end
`ifdef PATTERN_SEQ_BLANK_EN
            ST_BLANK: begin
               // Requests seen during the black frame stay pending for the next FB.
               pattern_n = target;
               change_n  = 1'b1;
               cnt_n     = '0;
               state_n   = mode_st;
            end
`endif
            default: state_n = ST_IDLE;
         endcase

         if (do_step) begin
            change_n = 1'b1;
            cnt_n    = '0;
`ifdef PATTERN_SEQ_BLANK_EN
            pattern_n = PATTERN_OFF;
            target_n  = step_to;
            state_n   = ST_BLANK;
`else
            pattern_n = step_to;
            state_n   = mode_st;
`endif
         end
      end
   end

   // Pending request: a pulse in the FB cycle itself lands after the clear,
   // so it survives to the next FB. Simultaneous Next+Prev cancel out.
   always_comb begin
      pending_n = consume ? PEND_NONE : pending;
      if (bus.i_Next && !bus.i_Prev)      pending_n = PEND_NEXT;
      else if (bus.i_Prev && !bus.i_Next) pending_n = PEND_PREV;
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state   <= ST_IDLE;
         pending <= PEND_NONE;
         pattern <= PATTERN_OFF;
         change  <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_n;
         pending <= pending_n;
         pattern <= pattern_n;
         change  <= change_n;
         cnt     <= cnt_n;
      end
   end

   assign bus.o_Pattern        = pattern;
   assign bus.o_Pattern_Change = change;
   assign bus.o_Frame_Count    = cnt;

endmodule
